// File: rtl/frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// frame_buffer_writer
//
// Accepts pixels {x, y, color} from a drawing engine, drops off-screen pixels,
// buffers on-screen pixels in a small FIFO and emits frame buffer writes
// through a single output register that holds while the memory stalls.
//
// Optional feature macro: FB_WRITER_CLIP_COUNT_EN
//   defined   -> clipped_count counts dropped pixels, saturating at 16'hFFFF
//   undefined -> clipped_count is tied to 0 and no counter exists
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high
//   xDraw/yDraw    in   11-bit pixel coordinates
//   color_in       in   3-bit pixel color
//   pix_valid      in   pixel present
//   pix_ready      out  a pixel can be accepted (FIFO not full)
//   fb_addr        out  19-bit frame buffer word address (y*SCREEN_W + x)
//   fb_data        out  3-bit color to write
//   fb_we          out  write request
//   fb_busy        in   memory stall; write not taken this cycle
//   clipped_count  out  number of off-screen pixels dropped
//   idle           out  FIFO empty and no write pending
// ---------------------------------------------------------------------------
module frame_buffer_writer #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] xDraw,
    input  logic [10:0] yDraw,
    input  logic [2:0]  color_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [18:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    input  logic        fb_busy,
    output logic [15:0] clipped_count,
    output logic        idle
);

    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [10:0] W11       = 11'(SCREEN_W);
    localparam logic [10:0] H11       = 11'(SCREEN_H);
    localparam logic [18:0] W19       = 19'(SCREEN_W);

    // FIFO entry layout: {x[10:0], y[10:0], color[2:0]}
    logic [24:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic          r_out_valid;
    logic [18:0]   r_addr;
    logic [2:0]    r_data;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_onscreen;
    logic          w_push;
    logic          w_pop;
    logic [24:0]   w_head;
    logic [10:0]   w_head_x;
    logic [10:0]   w_head_y;
    logic [2:0]    w_head_c;
    logic [18:0]   w_addr;

    assign w_full     = (r_count == DEPTH_CNT);
    assign w_empty    = (r_count == '0);
    assign w_accept   = pix_valid & ~w_full;
    assign w_onscreen = (xDraw < W11) && (yDraw < H11);
    assign w_push     = w_accept & w_onscreen;

    // Load the output register whenever it is free or its write completes now.
    assign w_pop      = ~w_empty & (~r_out_valid | ~fb_busy);

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_x   = w_head[24:14];
    assign w_head_y   = w_head[13:3];
    assign w_head_c   = w_head[2:0];

    // Widen before multiplying so y*SCREEN_W does not wrap at 11 bits.
    assign w_addr     = ({8'd0, w_head_y} * W19) + {8'd0, w_head_x};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {xDraw, yDraw, color_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_addr      <= w_addr;
            r_data      <= w_head_c;
        end else if (r_out_valid && !fb_busy) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef FB_WRITER_CLIP_COUNT_EN
    logic        w_clip;
    logic [15:0] r_clip_cnt;

    assign w_clip = w_accept & ~w_onscreen;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clip_cnt <= '0;
        end else if (w_clip && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    assign clipped_count = r_clip_cnt;
`else
    assign clipped_count = 16'd0;
`endif

    assign pix_ready = ~w_full;
    assign fb_we     = r_out_valid;
    assign fb_addr   = r_addr;
    assign fb_data   = r_data;
    assign idle      = w_empty & ~r_out_valid;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_writer
//
// Scoreboard bench: every on-screen pixel accepted by the DUT pushes its
// expected {color, address} into a queue; every completed write pops and
// compares. Directed scenarios cover single pixel latency, a streamed square,
// a memory stall filling the FIFO, clipping and reset mid-stream.
// ---------------------------------------------------------------------------
module tb_frame_buffer_writer;

    localparam int SW = 640;
    localparam int SH = 480;

    logic        clk;
    logic        reset;
    logic [10:0] xDraw;
    logic [10:0] yDraw;
    logic [2:0]  color_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [18:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_busy;
    logic [15:0] clipped_count;
    logic        idle;

    frame_buffer_writer #(
        .SCREEN_W   (SW),
        .SCREEN_H   (SH),
        .FIFO_DEPTH (8)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .xDraw         (xDraw),
        .yDraw         (yDraw),
        .color_in      (color_in),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_we         (fb_we),
        .fb_busy       (fb_busy),
        .clipped_count (clipped_count),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          cyc;
    int          wr_count;
    int          first_cyc;
    int          last_cyc;
    logic [18:0] first_addr;
    logic [18:0] last_addr;
    logic [21:0] sb [$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Write monitor: a write completes when fb_we=1 and fb_busy=0.
    always @(negedge clk) begin
        logic [21:0] exp_e;
        if (!reset && fb_we && !fb_busy) begin
            wr_count++;
            if (wr_count == 1) begin
                first_addr = fb_addr;
                first_cyc  = cyc;
            end
            last_addr = fb_addr;
            last_cyc  = cyc;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                check("fb_addr", 32'(fb_addr), 32'(exp_e[18:0]));
                check("fb_data", 32'(fb_data), 32'(exp_e[21:19]));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
    task automatic send_pix(input int x, input int y, input logic [2:0] c);
        int t;
        pix_valid = 1'b1;
        xDraw     = 11'(x);
        yDraw     = 11'(y);
        color_in  = c;
        t = 0;
        @(negedge clk);
        while (!pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            check("ready_timeout", 32'(pix_ready), 32'd1);
        end else if (x < SW && y < SH) begin
            sb.push_back({c, 19'(y * SW + x)});
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int t;
        t = 0;
        @(negedge clk);
        while (!idle && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 32'(idle), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        wr_count = 0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        wr_count  = 0;
        reset     = 1'b1;
        xDraw     = '0;
        yDraw     = '0;
        color_in  = '0;
        pix_valid = 1'b0;
        fb_busy   = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        do_reset(3);
        @(negedge clk);
        check("rst_fb_we",   32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_ready",   32'(pix_ready), 32'd1);
        check("rst_idle",    32'(idle), 32'd1);
        check("rst_clip",    32'(clipped_count), 32'd0);
        @(posedge clk);
        #1;

        // Single pixel: accepted in cycle N, fb_we at N+2, idle at N+3
        pix_valid = 1'b1;
        xDraw     = 11'd10;
        yDraw     = 11'd2;
        color_in  = 3'b101;
        @(negedge clk);
        check("single_ready", 32'(pix_ready), 32'd1);
        sb.push_back({3'b101, 19'd1290});
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        @(negedge clk);
        check("single_we_n1", 32'(fb_we), 32'd0);
        @(negedge clk);
        check("single_we_n2",   32'(fb_we), 32'd1);
        check("single_addr_n2", 32'(fb_addr), 32'd1290);
        check("single_data_n2", 32'(fb_data), 32'd5);
        @(negedge clk);
        check("single_idle_n3", 32'(idle), 32'd1);
        check("single_writes",  32'(wr_count), 32'd1);
        @(posedge clk);
        #1;

        // 11x11 square stream, raster order, no stalls
        do_reset(1);
        for (int y = 0; y <= 10; y++) begin
            for (int x = 0; x <= 10; x++) begin
                send_pix(x, y, 3'b111);
            end
        end
        wait_idle(40);
        check("sq_writes",     32'(wr_count), 32'd121);
        check("sq_first_addr", 32'(first_addr), 32'd0);
        check("sq_last_addr",  32'(last_addr), 32'd6410);
        check("sq_throughput", 32'(last_cyc - first_cyc), 32'd120);

        // Stall: 9 pixels while fb_busy=1 -> FIFO full plus one pending write
        do_reset(1);
        fb_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_pix(100 + i, 5, 3'(i));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_ready", 32'(pix_ready), 32'd0);
            check("stall_we",    32'(fb_we), 32'd1);
            check("stall_addr",  32'(fb_addr), 32'd3300);
            check("stall_data",  32'(fb_data), 32'd0);
        end
        @(posedge clk);
        #1;
        fb_busy = 1'b0;
        wait_idle(40);
        check("stall_writes", 32'(wr_count), 32'd9);
        check("stall_last",   32'(last_addr), 32'(5 * SW + 108));

        // Clipping
        do_reset(1);
        send_pix(639, 479, 3'b011);
        send_pix(640, 0,   3'b110);
        send_pix(0,   480, 3'b001);
        wait_idle(20);
        check("clip_writes", 32'(wr_count), 32'd1);
        check("clip_addr",   32'(last_addr), 32'd307199);
`ifdef FB_WRITER_CLIP_COUNT_EN
        check("clip_count", 32'(clipped_count), 32'd2);
`else
        check("clip_count", 32'(clipped_count), 32'd0);
`endif

        // Reset mid-stream with 5 pixels buffered behind a stall
        do_reset(1);
        fb_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_pix(20 + i, 7, 3'b010);
        end
        @(negedge clk);
        check("mid_busy_idle", 32'(idle), 32'd0);
        @(posedge clk);
        #1;
        do_reset(1);
        @(negedge clk);
        check("mid_we",    32'(fb_we), 32'd0);
        check("mid_idle",  32'(idle), 32'd1);
        check("mid_ready", 32'(pix_ready), 32'd1);
        @(posedge clk);
        #1;
        fb_busy = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_no_writes", 32'(wr_count), 32'd0);
        check("mid_clip",      32'(clipped_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_buffer_writer.md
FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 640, visible pixel columns.
REQ-002 The block SHALL have parameter SCREEN_H, default 480, visible pixel rows.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8 (power of two, at least 2), pixel buffer entries.
REQ-004 The block SHALL have port clk, input, 1 bit, single 50 MHz system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-006 The block SHALL have port xDraw, input, 11 bits, pixel x coordinate from the drawing engine.
REQ-007 The block SHALL have port yDraw, input, 11 bits, pixel y coordinate.
REQ-008 The block SHALL have port color_in, input, 3 bits, pixel color.
REQ-009 The block SHALL have port pix_valid, input, 1 bit, pixel present on xDraw/yDraw/color_in.
REQ-010 The block SHALL have port pix_ready, output, 1 bit, block can accept a pixel.
REQ-011 The block SHALL have port fb_addr, output, 19 bits, frame buffer word address.
REQ-012 The block SHALL have port fb_data, output, 3 bits, color to write.
REQ-013 The block SHALL have port fb_we, output, 1 bit, write request.
REQ-014 The block SHALL have port fb_busy, input, 1 bit, memory stall; a write is not taken this cycle.
REQ-015 The block SHALL have port clipped_count, output, 16 bits, number of off-screen pixels dropped.
REQ-016 The block SHALL have port idle, output, 1 bit, FIFO empty and no write pending.

Function
REQ-017 A pixel SHALL be accepted on a cycle with pix_valid=1 and pix_ready=1.
REQ-018 pix_ready SHALL equal NOT fifo_full; a push is never allowed when full, even if a pop happens in the same cycle.
REQ-019 An accepted pixel with xDraw>=SCREEN_W or yDraw>=SCREEN_H SHALL be clipped: not stored, no write, clipped_count incremented.
REQ-020 An on-screen accepted pixel SHALL be pushed into the FIFO with its {x, y, color}, preserving order.
REQ-021 The output stage SHALL be a single register (out_valid, addr, data), with fb_we equal to out_valid.
REQ-022 The output stage SHALL load from the FIFO head when the FIFO is non-empty and (out_valid=0 or fb_busy=0).
REQ-023 On load, addr SHALL be y*SCREEN_W+x computed at 19-bit width without truncation, and data SHALL be the stored color.
REQ-024 While fb_we=1 and fb_busy=1, fb_addr, fb_data and fb_we SHALL hold unchanged.
REQ-025 A write SHALL complete on a cycle with fb_we=1 and fb_busy=0; if the FIFO is empty then, out_valid SHALL clear next cycle.
REQ-026 Latency: a pixel accepted on cycle N into an empty block with fb_busy=0 SHALL appear as fb_we=1 on cycle N+2.
REQ-027 Throughput SHALL be one pixel per cycle sustained when fb_busy=0.
REQ-028 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 idle SHALL be 1 when the FIFO is empty and out_valid=0.

Reset
REQ-031 While reset=1 on a clock edge, FIFO pointers and occupancy SHALL clear, out_valid SHALL be 0, and clipped_count SHALL be 0.
REQ-032 After reset, the outputs SHALL be fb_we=0, fb_addr=0, fb_data=0, pix_ready=1 and idle=1.
REQ-033 Reset asserted mid-operation SHALL discard all buffered and pending pixels, with no further fb_we for them.

Configuration
REQ-034 With macro FB_WRITER_CLIP_COUNT_EN defined, clipped_count SHALL count clipped pixels and saturate at 16'hFFFF.
REQ-035 Without FB_WRITER_CLIP_COUNT_EN, clipped_count SHALL be constant 0 and no counter SHALL be built; clipping itself is unchanged.

Verification
REQ-036 The bench SHALL cover a single pixel: reset, then x=10, y=2, color=3'b101 valid for one cycle (N) -> fb_we=1 at N+2, fb_addr=1290, fb_data=3'b101, idle=1 at N+3.
REQ-037 The bench SHALL cover a 11x11 square stream from (0,0) to (10,10), color 3'b111, fb_busy=0 -> exactly 121 writes in raster order; first addr 0, last addr 6410.
REQ-038 The bench SHALL cover a stall: hold fb_busy=1 while pushing 9 pixels -> pix_ready=0 after FIFO full plus one pending write, fb signals held; release fb_busy -> all 9 written in order.
REQ-039 The bench SHALL cover clipping: pixels (639,479), (640,0), (0,480) -> one write at addr 307199; clipped_count=2 with the macro, 0 without.
REQ-040 The bench SHALL cover reset mid-stream: 5 pixels buffered with fb_busy=1, then reset for one cycle -> fb_we=0, idle=1, pix_ready=1 the cycle after, no writes of those pixels.
